// File: rtl/imem_loader.sv
// imem_loader: streams a byte image (16-bit little-endian word count, then
// little-endian 32-bit words) into instruction memory and holds the CPU until
// the image is in place.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;
  localparam state_t FIN = CSUM;
`else
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE, ERR} state_t;
  localparam state_t FIN = DONE;
`endif

  // Memory depth as a 17-bit quantity so it compares directly against a count.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]   widx_q, widx_d;   // one extra bit: a full image must not wrap to 0
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       asm_q, asm_d;     // lower three bytes of the word in progress
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic [16:0] hdr_cnt;

  // Handshake: stalls during a write pulse so a word always finishes cleanly.
  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      HDR0, HDR1, DATA: rx_ready = !we_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM:             rx_ready = !we_q;
`endif
      default:          rx_ready = 1'b0;
    endcase
  end

  assign accept    = rx_valid && rx_ready;
  assign hdr_cnt   = {1'b0, rx_data, cnt_q[7:0]};
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERR);

  // Next-state, word assembly and write-pulse generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = HDR0;
          cnt_d   = '0;
          widx_d  = '0;
          lane_d  = '0;
          asm_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      HDR0: begin
        if (accept) begin
          cnt_d[7:0] = rx_data;
          state_d    = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          cnt_d[15:8] = rx_data;
          if (hdr_cnt == 17'd0)      state_d = FIN;
          else if (hdr_cnt > DEPTH)  state_d = ERR;
          else                       state_d = DATA;
        end
      end
      DATA: begin
        if (we_q && (17'(widx_q) == {1'b0, cnt_q})) begin
          state_d = FIN;
        end else if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          case (lane_q)
            2'd0: asm_d[7:0]   = rx_data;
            2'd1: asm_d[15:8]  = rx_data;
            2'd2: asm_d[23:16] = rx_data;
            default: begin
              we_d    = 1'b1;
              addr_d  = widx_q[ADDR_W-1:0];
              wdata_d = {rx_data, asm_q};
              widx_d  = widx_q + 1'b1;
            end
          endcase
          lane_d = lane_q + 2'd1;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) state_d = (rx_data == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction memory word-address width (depth 2^ADDR_W words, 256 by default, matching pc[9:2] fetch indexing).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; begins a load session.
REQ-005 rx_valid  input  1  byte-stream source has a byte.
REQ-006 rx_data  input  8  byte from source.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
REQ-009 mem_addr  output  ADDR_W  word address of the write.
REQ-010 mem_wdata  output  32  instruction word to write.
REQ-011 cpu_hold  output  1  holds the fetch PC and pipeline while the image is not valid.
REQ-012 done  output  1  image loaded successfully; sticky.
REQ-013 error  output  1  load failed; sticky.

Function
REQ-014 States: IDLE, HDR0, HDR1, DATA, CSUM (macro only), DONE, ERR.
REQ-015 Byte accepted only when rx_valid && rx_ready; rx_ready = 1 exactly in HDR0, HDR1, DATA, CSUM.
REQ-016 IDLE/DONE/ERR + start -> HDR0; clears done, error, word counter, byte lane, checksum. start in any other state is ignored.
REQ-017 HDR0 accepts count[7:0]; HDR1 accepts count[15:8]; the 16-bit count is the number of words to write.
REQ-018 After HDR1: count == 0 -> DONE (or CSUM with macro); count > 2^ADDR_W -> ERR; otherwise -> DATA.
REQ-019 DATA: bytes little-endian; byte k of word lands in wdata[8k+7:8k].
REQ-020 In the cycle after the 4th byte of a word is accepted: mem_we = 1, mem_addr = word index (0,1,2,...), mem_wdata = assembled word; mem_we = 0 otherwise.
REQ-021 Word index is ADDR_W+1 bits internally; a count of exactly 2^ADDR_W writes addresses 0..2^ADDR_W-1 with no wrap onto address 0.
REQ-022 After the last word's write pulse: -> DONE (or CSUM with macro); rx_ready = 0 in the write-pulse cycle.
REQ-023 cpu_hold = 1 in HDR0, HDR1, DATA, CSUM and ERR; 0 in IDLE and DONE.
REQ-024 done = 1 only in DONE; error = 1 only in ERR; both stay until the next start or rst.
REQ-025 Idle rx_valid in IDLE/DONE/ERR is not consumed (rx_ready = 0).

Reset
REQ-026 rst = 1 at a clock edge -> state IDLE, rx_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_hold = 0, done = 0, error = 0, counters and checksum = 0.
REQ-027 rst mid-session aborts with no further write; a partially assembled word is discarded.
REQ-028 rst overrides a simultaneous start.

Configuration
REQ-029 Macro IMEM_LOADER_CHECKSUM_EN.
REQ-030 With it defined: running XOR of all DATA bytes; after the last word (or count 0), CSUM accepts one byte; match -> DONE, mismatch -> ERR (words already written remain, cpu_hold stays 1).
REQ-031 Without it: no CSUM state, no checksum logic; DATA -> DONE directly.

Verification
REQ-032 rst, start, bytes 02 00 13 00 00 00 B3 00 50 00 -> mem_we pulses at addr 0 data 0x00000013 and addr 1 data 0x005000B3; done = 1, cpu_hold = 0.
REQ-033 Header 00 00 -> no mem_we; done = 1 (macro on: checksum byte 00 required first).
REQ-034 Header 01 01 (257 words, ADDR_W = 8) -> error = 1, cpu_hold = 1, rx_ready = 0, no mem_we.
REQ-035 Macro on: 1 word AA BB CC DD, checksum 00 -> done; same word, checksum 01 -> error; XOR AA^BB^CC^DD = 0x00.
REQ-036 rx_valid toggled 1/0 every cycle during DATA -> same writes as the continuous case; rst asserted after 2 data bytes -> IDLE, no mem_we, all outputs 0.
